// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI bridge: directory entry layout, read-response record, AXI encodings.
// Pure declarations; no timing or flow-control behaviour lives here.
package apb2axi_pkg;

   localparam int AXI_DATA_W = 32;
   localparam int AXI_ADDR_W = 32;
   localparam int TAG_W      = 4;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic                  is_write;
      logic [TAG_W-1:0]      tag;
      logic [2:0]            size;
      logic [7:0]            len;
      logic [AXI_ADDR_W-1:0] addr;
   } directory_entry_t;

   localparam int REQ_WIDTH = $bits(directory_entry_t);

   typedef struct packed {
      logic [AXI_DATA_W-1:0] data;
      logic [TAG_W-1:0]      tag;
      logic [1:0]            resp;
      logic                  last;
   } rd_rsp_t;

   localparam int RSP_WIDTH = $bits(rd_rsp_t);

   typedef enum logic [1:0] {IDLE, AR, DATA, DRAIN} rd_state_e;

endpackage

// File: rtl/apb2axi_rd_engine.sv
// Pops one read entry, issues a single AR burst (valid 1 cycle after pop) and forwards each R beat to the response FIFO.
// R to push is combinational: a full response FIFO drops rready, so nothing is buffered or lost.
module apb2axi_rd_engine
   import apb2axi_pkg::*;
#(
   parameter int REQ_W  = REQ_WIDTH,
   parameter int DATA_W = AXI_DATA_W,
   parameter int ADDR_W = AXI_ADDR_W,
   parameter int ID_W   = TAG_W
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 rd_req_valid,
   output logic                 rd_req_ready,
   input  logic [REQ_W-1:0]     rd_req_data,
   output logic [ID_W-1:0]      m_axi_arid,
   output logic [ADDR_W-1:0]    m_axi_araddr,
   output logic [7:0]           m_axi_arlen,
   output logic [2:0]           m_axi_arsize,
   output logic [1:0]           m_axi_arburst,
   output logic                 m_axi_arvalid,
   input  logic                 m_axi_arready,
   input  logic [ID_W-1:0]      m_axi_rid,
   input  logic [DATA_W-1:0]    m_axi_rdata,
   input  logic [1:0]           m_axi_rresp,
   input  logic                 m_axi_rlast,
   input  logic                 m_axi_rvalid,
   output logic                 m_axi_rready,
   output logic                 rsp_push_valid,
   input  logic                 rsp_push_ready,
   output logic [RSP_WIDTH-1:0] rsp_push_data,
   output logic                 busy,
   output logic                 proto_err,
   input  logic                 proto_err_clr
);

   rd_state_e        state_q, state_d;
   directory_entry_t req_q, req_d;
   logic [7:0]       beat_cnt_q, beat_cnt_d;
   logic             proto_err_q, proto_err_d;
   logic             err_set;
   logic             r_hs;
   logic             last_beat;
   logic             id_bad;
   rd_rsp_t          rsp;
   // Read entries never carry a write; the flag is captured with the entry but has no use here.
   logic             unused_is_write;

   assign r_hs            = m_axi_rvalid && m_axi_rready;
   assign last_beat       = (beat_cnt_q == req_q.len);
   assign id_bad          = (m_axi_rid != req_q.tag);
   assign unused_is_write = req_q.is_write;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         beat_cnt_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         beat_cnt_q  <= beat_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      beat_cnt_d = beat_cnt_q;
      err_set    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_req_valid) begin
               req_d   = rd_req_data;
               state_d = AR;
            end
         end
         AR: begin
            if (m_axi_arready) begin
               beat_cnt_d = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (r_hs) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               // rlast disagreeing with the beat count covers both early and missing last
               err_set = id_bad || (m_axi_rlast != last_beat);
               if (m_axi_rlast) begin
                  state_d = IDLE;
               end else if (last_beat) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (m_axi_rvalid && m_axi_rlast) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      proto_err_d = err_set ? 1'b1 : (proto_err_clr ? 1'b0 : proto_err_q);
   end

   always_comb begin
      rd_req_ready   = 1'b0;
      m_axi_arvalid  = 1'b0;
      m_axi_arburst  = 2'b00;
      m_axi_rready   = 1'b0;
      rsp_push_valid = 1'b0;
      rsp            = '0;
      case (state_q)
         IDLE: rd_req_ready = rd_req_valid && !areset;
         AR: begin
            m_axi_arvalid = 1'b1;
            m_axi_arburst = AXI_BURST_INCR;
         end
         DATA: begin
            m_axi_rready   = rsp_push_ready;
            rsp_push_valid = m_axi_rvalid;
            rsp.data       = m_axi_rdata;
            rsp.tag        = req_q.tag;
            rsp.resp       = (id_bad || (last_beat && !m_axi_rlast)) ? AXI_RESP_SLVERR : m_axi_rresp;
            rsp.last       = m_axi_rlast || last_beat;
         end
         DRAIN: m_axi_rready = 1'b1;
         default: ;
      endcase
   end

   assign m_axi_arid    = req_q.tag;
   assign m_axi_araddr  = req_q.addr;
   assign m_axi_arlen   = req_q.len;
   assign m_axi_arsize  = req_q.size;
   assign rsp_push_data = rsp;
   assign busy          = (state_q != IDLE);
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_apb2axi_rd_engine.sv
// Bench for apb2axi_rd_engine: table rows, hand-written reset sequence, randomized transactions vs a beat-list model.
`timescale 1ns/1ps
module tb_apb2axi_rd_engine;
   import apb2axi_pkg::*;

   logic                  aclk = 1'b0;
   logic                  areset;
   logic                  rd_req_valid, rd_req_ready;
   logic [REQ_WIDTH-1:0]  rd_req_data;
   logic [TAG_W-1:0]      m_axi_arid, m_axi_rid;
   logic [AXI_ADDR_W-1:0] m_axi_araddr;
   logic [7:0]            m_axi_arlen;
   logic [2:0]            m_axi_arsize;
   logic [1:0]            m_axi_arburst, m_axi_rresp;
   logic                  m_axi_arvalid, m_axi_arready;
   logic [AXI_DATA_W-1:0] m_axi_rdata;
   logic                  m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic                  rsp_push_valid, rsp_push_ready;
   logic [RSP_WIDTH-1:0]  rsp_push_data;
   logic                  busy, proto_err, proto_err_clr;

   always #5 aclk = ~aclk;

   apb2axi_rd_engine dut (
      .aclk(aclk), .areset(areset),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_data(rd_req_data),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .rsp_push_valid(rsp_push_valid), .rsp_push_ready(rsp_push_ready), .rsp_push_data(rsp_push_data),
      .busy(busy), .proto_err(proto_err), .proto_err_clr(proto_err_clr)
   );

   typedef struct packed {
      logic [TAG_W-1:0]      id;
      logic [AXI_DATA_W-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } beat_t;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [3:0]  tag;
      int          nbeats;
      int          last_at;
      int          bad_at;
      logic [1:0]  resp;
      int          ar_delay;
      int          bp;
      int          exp_npush;
      bit          exp_err;
   } vec_t;

   beat_t   beats[$];
   rd_rsp_t exp_q[$];
   rd_rsp_t got_q[$];
   bit      berr[$];
   bit      exp_err = 1'b0;
   int      vectors = 0;
   int      miscompares = 0;
   vec_t    tbl[8];

   always @(negedge aclk)
      if (!areset && rsp_push_valid && rsp_push_ready) got_q.push_back(rsp_push_data);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic build_beats(input logic [3:0] tg, input int nb, input int last_at,
                              input int bad_at, input logic [1:0] rs);
      beat_t b;
      beats.delete();
      for (int i = 0; i < nb; i++) begin
         b.id   = (i == bad_at) ? (tg ^ 4'h1) : tg;
         b.data = $urandom;
         b.resp = rs;
         b.last = (i == last_at);
         beats.push_back(b);
      end
   endtask

   // Expected pushes: beats up to the first rlast or the len+1'th beat are pushed; the rest are drained.
   function automatic void model(input logic [7:0] len, input logic [3:0] tg);
      int n    = int'(len) + 1;
      bit done = 1'b0;
      exp_q.delete();
      berr.delete();
      foreach (beats[i]) begin
         rd_rsp_t r;
         bit bad, miss, early, fin;
         if (done) begin
            berr.push_back(1'b0);
            continue;
         end
         bad    = (beats[i].id != tg);
         miss   = (i == n - 1) && !beats[i].last;
         early  = beats[i].last && (i < n - 1);
         fin    = beats[i].last || (i == n - 1);
         r.data = beats[i].data;
         r.tag  = tg;
         r.resp = (bad || miss) ? AXI_RESP_SLVERR : beats[i].resp;
         r.last = fin;
         exp_q.push_back(r);
         berr.push_back(bad || miss || early);
         done = fin;
      end
   endfunction

   task automatic run_txn(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [3:0] tg, input int ar_delay, input int bp,
                          input int gap, input int clr_pct);
      directory_entry_t e;
      int bi = 0, cyc = 0, dcyc = 0, ar_cnt = 0, nb, budget;
      bit ar_done = 1'b0, pend = 1'b0, finished = 1'b0, set;
      e = '{is_write: 1'b0, tag: tg, size: sz, len: len, addr: a};
      nb = beats.size();
      budget = 8 * nb + ar_delay + 50;
      model(len, tg);
      got_q.delete();
      rd_req_data = e;
      rd_req_valid = 1'b1;
      proto_err_clr = 1'b0;
      @(negedge aclk);
      chk("pop_ready", rd_req_ready, 1);
      chk("arvalid_at_pop", m_axi_arvalid, 0);
      chk("proto_err", proto_err, exp_err);
      step();
      rd_req_data = ~e;
      while (cyc < budget && !finished) begin
         rd_req_valid  = (bi < nb);
         m_axi_arready = (cyc >= ar_delay);
         if (!pend) begin
            if (ar_done && bi < nb && $urandom_range(99) >= gap) begin
               m_axi_rid = beats[bi].id;   m_axi_rdata = beats[bi].data;
               m_axi_rresp = beats[bi].resp; m_axi_rlast = beats[bi].last;
               m_axi_rvalid = 1'b1;
               pend = 1'b1;
            end else begin
               m_axi_rvalid = 1'b0;
            end
         end
         rsp_push_ready = (bp < 0) ? !(dcyc >= 2 && dcyc <= 4) : ($urandom_range(99) >= bp);
         proto_err_clr  = ($urandom_range(99) < clr_pct);
         @(negedge aclk);
         set = 1'b0;
         if (ar_done && bi == nb && !busy) begin
            finished = 1'b1;
         end else begin
            chk("busy", busy, 1);
            chk("no_pop_busy", rd_req_ready, 0);
            if (!ar_done) begin
               chk("arvalid", m_axi_arvalid, 1);
               chk("arid", m_axi_arid, tg);
               chk("araddr", m_axi_araddr, a);
               chk("arlen", m_axi_arlen, len);
               chk("arsize", m_axi_arsize, sz);
               chk("arburst", m_axi_arburst, 2'b01);
               ar_cnt++;
               if (m_axi_arready) ar_done = 1'b1;
            end else begin
               chk("arvalid_after_hs", m_axi_arvalid, 0);
               if (bi < exp_q.size()) begin
                  chk("rready_follows_push_ready", m_axi_rready, rsp_push_ready);
                  chk("push_valid_follows_rvalid", rsp_push_valid, m_axi_rvalid);
               end else begin
                  chk("drain_rready", m_axi_rready, 1);
                  chk("drain_no_push", rsp_push_valid, 0);
               end
               if (m_axi_rvalid && m_axi_rready && bi < nb) begin
                  set = berr[bi];
                  bi++;
                  pend = 1'b0;
               end
               dcyc++;
            end
         end
         chk("proto_err", proto_err, exp_err);
         exp_err = set ? 1'b1 : (proto_err_clr ? 1'b0 : exp_err);
         step();
         cyc++;
      end
      rd_req_valid = 1'b0;  m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      m_axi_rlast = 1'b0;   proto_err_clr = 1'b0; rsp_push_ready = 1'b0;
      chk("txn_done", finished, 1);
      chk("ar_cycles", ar_cnt, ar_delay + 1);
      chk("beats_consumed", bi, nb);
      chk("npush", got_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < got_q.size()) chk("push_beat", got_q[i], exp_q[i]);
   endtask

   task automatic chk_all_zero(input string ph);
      chk({ph, "_rd_req_ready"}, rd_req_ready, 0);
      chk({ph, "_arvalid"}, m_axi_arvalid, 0);
      chk({ph, "_arid"}, m_axi_arid, 0);
      chk({ph, "_araddr"}, m_axi_araddr, 0);
      chk({ph, "_arlen"}, m_axi_arlen, 0);
      chk({ph, "_arsize"}, m_axi_arsize, 0);
      chk({ph, "_arburst"}, m_axi_arburst, 0);
      chk({ph, "_rready"}, m_axi_rready, 0);
      chk({ph, "_push_valid"}, rsp_push_valid, 0);
      chk({ph, "_push_data"}, rsp_push_data, 0);
      chk({ph, "_busy"}, busy, 0);
      chk({ph, "_proto_err"}, proto_err, 0);
   endtask

   initial begin
      directory_entry_t e;
      areset = 1'b1; rd_req_valid = 1'b0; rd_req_data = '0;
      m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; rsp_push_ready = 1'b0; proto_err_clr = 1'b0;

      tbl[0] = '{"single",       32'h1000,   8'd0, 4'd3,   1,   0, -1, 2'b00, 0,  0,   1, 1'b0};
      tbl[1] = '{"burst4_ar5",   32'h2000,   8'd3, 4'd7,   4,   3, -1, 2'b00, 5,  0,   4, 1'b0};
      tbl[2] = '{"backpressure", 32'h3000,   8'd3, 4'd1,   4,   3, -1, 2'b00, 0, -1,   4, 1'b0};
      tbl[3] = '{"len255",       32'h4000, 8'd255, 4'd9, 256, 255, -1, 2'b00, 1,  0, 256, 1'b0};
      tbl[4] = '{"decerr_pass",  32'h5000,   8'd1, 4'd2,   2,   1, -1, 2'b11, 0, 25,   2, 1'b0};
      tbl[5] = '{"bad_rid",      32'h6000,   8'd2, 4'd4,   3,   2,  1, 2'b00, 2,  0,   3, 1'b1};
      tbl[6] = '{"early_last",   32'h7000,   8'd3, 4'd6,   2,   1, -1, 2'b00, 0,  0,   2, 1'b1};
      tbl[7] = '{"missing_last", 32'h8000,   8'd1, 4'd5,   3,   2, -1, 2'b00, 0,  0,   2, 1'b1};

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk_all_zero("in_reset");
      step();
      areset = 1'b0;
      @(negedge aclk);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_proto_err", proto_err, 0);
      step();

      for (int r = 0; r < 8; r++) begin
         proto_err_clr = 1'b1;
         step();
         proto_err_clr = 1'b0;
         exp_err = 1'b0;
         chk({tbl[r].name, "_cleared"}, proto_err, 0);
         build_beats(tbl[r].tag, tbl[r].nbeats, tbl[r].last_at, tbl[r].bad_at, tbl[r].resp);
         run_txn(tbl[r].addr, tbl[r].len, 3'd2, tbl[r].tag, tbl[r].ar_delay, tbl[r].bp, 0, 0);
         chk({tbl[r].name, "_npush"}, got_q.size(), tbl[r].exp_npush);
         chk({tbl[r].name, "_err"}, proto_err, tbl[r].exp_err);
         if (got_q.size() > 0) begin
            chk({tbl[r].name, "_final_last"}, got_q[got_q.size()-1].last, 1);
            chk({tbl[r].name, "_tag"}, got_q[0].tag, tbl[r].tag);
         end
      end

      // Reset mid-DATA with proto_err still set from the missing-last row
      e = '{is_write: 1'b0, tag: 4'd5, size: 3'd2, len: 8'd3, addr: 32'h9000};
      rd_req_data = e; rd_req_valid = 1'b1;
      step();
      rd_req_valid = 1'b0; m_axi_arready = 1'b1;
      step();
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rid = 4'd5;
      m_axi_rdata = 32'hCAFE0000; m_axi_rlast = 1'b0; rsp_push_ready = 1'b1;
      step();
      chk("mid_data_busy", busy, 1);
      chk("mid_data_rready", m_axi_rready, 1);
      areset = 1'b1; rd_req_valid = 1'b1;
      @(negedge aclk);
      chk_all_zero("mid_reset");
      step();
      areset = 1'b0; rd_req_valid = 1'b0; m_axi_rvalid = 1'b0; rsp_push_ready = 1'b0;
      exp_err = 1'b0;
      step();
      build_beats(4'd8, 3, 2, -1, 2'b00);
      run_txn(32'hA000, 8'd2, 3'd3, 4'd8, 1, 0, 0, 0);
      chk("after_reset_err", proto_err, 0);

      for (int t = 0; t < 40; t++) begin
         logic [7:0] len;
         logic [3:0] tg;
         int L, scen, nb, last_at;
         len  = 8'($urandom_range(0, 15));
         tg   = 4'($urandom);
         L    = int'(len);
         scen = $urandom_range(0, 9);
         if (scen == 7 && L > 0) begin
            last_at = $urandom_range(0, L - 1);
         end else if (scen >= 8) begin
            last_at = L + 1 + $urandom_range(0, 2);
         end else begin
            last_at = L;
         end
         nb = last_at + 1;
         build_beats(tg, nb, last_at, -1, 2'b00);
         foreach (beats[i]) begin
            beats[i].resp = 2'($urandom);
            if ($urandom_range(0, 19) == 0) beats[i].id = tg ^ 4'h2;
         end
         run_txn($urandom, len, 3'($urandom), tg, $urandom_range(0, 4),
                 $urandom_range(0, 50), $urandom_range(0, 50), 20);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
